pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the rvga core; next generation of the fixed 6-stage stall/flush unit.
//  Generates per-stage stall and flush vectors for NUM_STAGES stages (stage 0 = ifetch).
//  Adds a load-use scoreboard with bubble insertion, flush deferral across memory stalls,
//  and a memory-wait watchdog with a sticky timeout flag.
// PARAMETERS
//  NUM_STAGES   6    pipeline depth, >=3; stage 0 = ifetch, NUM_STAGES-1 = writeback
//  REG_ADDR_W   5    register address width; scoreboard holds 2**REG_ADDR_W bits
//  LU_STAGE     2    operand-read stage; load-use stall covers stages 0..LU_STAGE
//  TIMEOUT_W    8    watchdog counter width
//  MEM_TIMEOUT  255  consecutive memory-stall cycles that set timeout; must be <= 2**TIMEOUT_W-1
// PORTS
//  clk_i            in   1             clock
//  reset_n_i        in   1             async active-low reset
//  imem_read_v_i    in   1             instruction fetch outstanding
//  imem_resp_v_i    in   1             instruction response valid
//  dmem_read_v_i    in   1             data access outstanding
//  dmem_resp_v_i    in   1             data response valid
//  br_v_i           in   NUM_STAGES    br_v_i[k]: redirect resolved in stage k; bit 0 ignored
//  ld_issue_v_i     in   1             load leaving LU_STAGE+1 (execute) this cycle
//  ld_issue_rd_i    in   REG_ADDR_W    destination of issuing load
//  ld_done_v_i      in   1             load data written back this cycle
//  ld_done_rd_i     in   REG_ADDR_W    destination of completing load
//  rs1_v_i, rs2_v_i in   1             consumer in LU_STAGE reads rs1/rs2
//  rs1_i, rs2_i     in   REG_ADDR_W    consumer source registers
//  clr_timeout_i    in   1             clears sticky timeout
//  stall_v_o        out  NUM_STAGES    per-stage hold
//  flush_v_o        out  NUM_STAGES-1  per-stage squash, stages 0..NUM_STAGES-2
//  bubble_v_o       out  1             inject NOP into stage LU_STAGE+1
//  timeout_v_o      out  1             sticky watchdog flag
// BEHAVIOUR
//  Reset (async, reset_n_i=0):
//   - scoreboard, flush_pend_r, wd_cnt_r and timeout_v_o cleared.
//   - All outputs 0 while held in reset.
//  mem_stall = (imem_read_v_i & ~imem_resp_v_i) | (dmem_read_v_i & ~dmem_resp_v_i); combinational, zero latency.
//  Flush:
//   - br_mask[j] = OR of br_v_i[k] for k>j; a redirect squashes every younger stage, not only the adjacent one.
//   - mem_stall=0: flush_v_o = br_mask | flush_pend_r; flush_pend_r <= 0 next edge.
//   - mem_stall=1: flush_v_o = 0; flush_pend_r <= flush_pend_r | br_mask.
//     Pending flush is issued on the first non-stall cycle.
//  Scoreboard (sb[2**REG_ADDR_W]):
//   - ld_issue_v_i sets sb[rd] at the next edge; ld_done_v_i clears sb[rd].
//   - rd==0 never set.
//   - Same rd set and cleared in the same cycle: set wins.
//  Load-use:
//   - lu_haz = (rs1_v_i & sb[rs1_i] & rs1_i!=0) | (rs2_v_i & sb[rs2_i] & rs2_i!=0).
//   - Uses registered sb only; no same-cycle bypass from ld_done, so one extra stall cycle results.
//  Stall/bubble:
//   - stall_v_o[j] = mem_stall | (lu_haz & j<=LU_STAGE).
//   - bubble_v_o = lu_haz & ~mem_stall & ~flush_v_o[LU_STAGE].
//   - Flush of stage j dominates stall of stage j; the stage squashes.
//  Watchdog:
//   - wd_cnt_r increments each mem_stall cycle, saturating at all-ones; resets to 0 on any cycle with mem_stall=0.
//   - When wd_cnt_r==MEM_TIMEOUT-1 and mem_stall=1, timeout_v_o <= 1.
//   - timeout_v_o is cleared only by clr_timeout_i or reset; set has priority over clr in the same cycle.
//   - The watchdog does not release stalls.
//  Async reset asserted mid-stall: pending flushes and scoreboard entries are discarded.
// TESTING
//  1. imem_read_v_i=1, imem_resp_v_i=0 for 3 cycles -> stall_v_o=6'b111111 those cycles, flush_v_o=0.
//     resp -> stall_v_o=0.
//  2. br_v_i[3]=1, no stall -> flush_v_o=5'b00111 same cycle; br_v_i[5] -> 5'b11111.
//  3. dmem stall, br_v_i[2] pulsed mid-stall -> flush_v_o=0 during stall.
//     5'b00011 on first free cycle, 0 after.
//  4. Load to x5 issued; next cycle rs1_i=5, rs1_v_i=1 -> stall_v_o=6'b000111, bubble_v_o=1 until cycle after ld_done x5.
//     Same sequence with rd=0 -> no stall.
//  5. MEM_TIMEOUT=4, dmem stalled 4 cycles -> timeout_v_o=1 after 4th edge, stays set after resp.
//     clr_timeout_i -> 0.
//  6. reset_n_i low mid-load-use stall -> all outputs 0 immediately.
//     After release, rs1 match does not stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller for the rvga core. It produces per-stage stall
//   and flush vectors for a NUM_STAGES-deep pipeline (stage 0 = ifetch,
//   stage NUM_STAGES-1 = writeback). It also provides:
//     - a load-use scoreboard with bubble insertion;
//     - flush deferral while memory is stalled;
//     - a memory-wait watchdog with a sticky timeout flag.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   imem_read_v_i/resp_v_i    instruction fetch outstanding / response valid
//   dmem_read_v_i/resp_v_i    data access outstanding / response valid
//   br_v_i[NUM_STAGES]        redirect resolved in stage k (bit 0 unused)
//   ld_issue_v_i/rd_i         load leaving execute, its destination
//   ld_done_v_i/rd_i          load written back, its destination
//   rs1/rs2_v_i, rs1/rs2_i    consumer in LU_STAGE and its source registers
//   clr_timeout_i             clears the sticky timeout flag
//   stall_v_o[NUM_STAGES]     per-stage hold
//   flush_v_o[NUM_STAGES-1]   per-stage squash for stages 0..NUM_STAGES-2
//   bubble_v_o                inject a NOP into stage LU_STAGE+1
//   timeout_v_o               sticky watchdog flag
//
// Memory handshake
//   *_read_v_i high means an access is outstanding. A *_resp_v_i pulse in the
//   same cycle completes that access. Any cycle with an outstanding access and
//   no response is a memory stall. A memory stall holds every stage, and it is
//   visible combinationally in the same cycle.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES  = 6,
  parameter int REG_ADDR_W  = 5,
  parameter int LU_STAGE    = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  imem_read_v_i,
  input  logic                  imem_resp_v_i,
  input  logic                  dmem_read_v_i,
  input  logic                  dmem_resp_v_i,
  input  logic [NUM_STAGES-1:0] br_v_i,
  input  logic                  ld_issue_v_i,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd_i,
  input  logic                  ld_done_v_i,
  input  logic [REG_ADDR_W-1:0] ld_done_rd_i,
  input  logic                  rs1_v_i,
  input  logic                  rs2_v_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  clr_timeout_i,
  output logic [NUM_STAGES-1:0] stall_v_o,
  output logic [NUM_STAGES-2:0] flush_v_o,
  output logic                  bubble_v_o,
  output logic                  timeout_v_o
);

  localparam int SB_N = 2 ** REG_ADDR_W;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic                  mem_stall;
  logic [NUM_STAGES-2:0] br_mask;
  logic [NUM_STAGES-2:0] flush_int;
  logic [NUM_STAGES-1:0] flush_ext;
  logic [NUM_STAGES-1:0] stall_int;
  logic                  lu_haz;
  logic                  bubble_int;
  logic                  unused_br0;

  logic [NUM_STAGES-2:0] flush_pend_q, flush_pend_d;
  logic [SB_N-1:0]       sb_q, sb_d;
  logic [TIMEOUT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic                  timeout_q, timeout_d;

  // A redirect in stage 0 has no younger stage to squash.
  assign unused_br0 = br_v_i[0];

  assign mem_stall = (imem_read_v_i & ~imem_resp_v_i) | (dmem_read_v_i & ~dmem_resp_v_i);

  // A redirect in stage k squashes every younger stage j < k.
  always_comb begin
    br_mask = '0;
    for (int j = 0; j < NUM_STAGES - 1; j++) begin
      for (int k = j + 1; k < NUM_STAGES; k++) begin
        br_mask[j] = br_mask[j] | br_v_i[k];
      end
    end
  end

  // Redirects that arrive during a memory stall are held. They are issued on
  // the first free cycle, together with any new redirect from that cycle.
  always_comb begin
    if (mem_stall) begin
      flush_int    = '0;
      flush_pend_d = flush_pend_q | br_mask;
    end else begin
      flush_int    = br_mask | flush_pend_q;
      flush_pend_d = '0;
    end
  end

  // Scoreboard update. The set is applied after the clear, so an issue and a
  // completion to the same rd in one cycle leave the entry set. x0 never
  // carries a hazard.
  always_comb begin
    sb_d = sb_q;
    if (ld_done_v_i) sb_d[ld_done_rd_i] = 1'b0;
    if (ld_issue_v_i && (ld_issue_rd_i != '0)) sb_d[ld_issue_rd_i] = 1'b1;
  end

  // Only the registered scoreboard is used. A completing load still stalls
  // its consumer for that cycle.
  assign lu_haz = (rs1_v_i & sb_q[rs1_i] & (rs1_i != '0)) |
                  (rs2_v_i & sb_q[rs2_i] & (rs2_i != '0));

  // The writeback stage is never flushed; pad so the stall loop can index it.
  assign flush_ext = {1'b0, flush_int};

  // A squashing stage does not also hold.
  always_comb begin
    stall_int = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      stall_int[j] = (mem_stall | (lu_haz & (j <= LU_STAGE))) & ~flush_ext[j];
    end
  end

  assign bubble_int = lu_haz & ~mem_stall & ~flush_int[LU_STAGE];

  // Watchdog. It counts consecutive memory-stall cycles and saturates. The
  // set has priority over the clear. It only reports; stalls are unaffected.
  always_comb begin
    if (mem_stall) begin
      wd_cnt_d = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + TIMEOUT_W'(1);
    end else begin
      wd_cnt_d = '0;
    end
    timeout_d = timeout_q;
    if (clr_timeout_i) timeout_d = 1'b0;
    if (mem_stall && (wd_cnt_q == WD_LAST)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flush_pend_q <= '0;
      sb_q         <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
      sb_q         <= sb_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // The combinational paths are gated so that every output is 0 while reset
  // is held.
  assign stall_v_o   = reset_n_i ? stall_int : '0;
  assign flush_v_o   = reset_n_i ? flush_int : '0;
  assign bubble_v_o  = reset_n_i & bubble_int;
  assign timeout_v_o = reset_n_i & timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. It uses NUM_STAGES=6, LU_STAGE=2 and
//   MEM_TIMEOUT=4. Inputs change 1ns after a rising edge. Outputs are checked
//   1ns later, well away from the next edge.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       imem_read_v_i, imem_resp_v_i, dmem_read_v_i, dmem_resp_v_i;
  logic [5:0] br_v_i;
  logic       ld_issue_v_i, ld_done_v_i;
  logic [4:0] ld_issue_rd_i, ld_done_rd_i;
  logic       rs1_v_i, rs2_v_i;
  logic [4:0] rs1_i, rs2_i;
  logic       clr_timeout_i;
  logic [5:0] stall_v_o;
  logic [4:0] flush_v_o;
  logic       bubble_v_o, timeout_v_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(
    .NUM_STAGES (6),
    .REG_ADDR_W (5),
    .LU_STAGE   (2),
    .TIMEOUT_W  (8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .imem_read_v_i(imem_read_v_i),
    .imem_resp_v_i(imem_resp_v_i),
    .dmem_read_v_i(dmem_read_v_i),
    .dmem_resp_v_i(dmem_resp_v_i),
    .br_v_i       (br_v_i),
    .ld_issue_v_i (ld_issue_v_i),
    .ld_issue_rd_i(ld_issue_rd_i),
    .ld_done_v_i  (ld_done_v_i),
    .ld_done_rd_i (ld_done_rd_i),
    .rs1_v_i      (rs1_v_i),
    .rs2_v_i      (rs2_v_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .clr_timeout_i(clr_timeout_i),
    .stall_v_o    (stall_v_o),
    .flush_v_o    (flush_v_o),
    .bubble_v_o   (bubble_v_o),
    .timeout_v_o  (timeout_v_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // driver tasks
  task automatic idle();
    imem_read_v_i = 1'b0; imem_resp_v_i = 1'b0;
    dmem_read_v_i = 1'b0; dmem_resp_v_i = 1'b0;
    br_v_i = '0;
    ld_issue_v_i = 1'b0; ld_issue_rd_i = '0;
    ld_done_v_i  = 1'b0; ld_done_rd_i  = '0;
    rs1_v_i = 1'b0; rs1_i = '0;
    rs2_v_i = 1'b0; rs2_i = '0;
    clr_timeout_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    idle();
    reset_n_i = 1'b0;
    #12;
    check("rst_stall",   32'(stall_v_o),   32'h0);
    check("rst_flush",   32'(flush_v_o),   32'h0);
    check("rst_bubble",  32'(bubble_v_o),  32'h0);
    check("rst_timeout", 32'(timeout_v_o), 32'h0);
    reset_n_i = 1'b1;
    tick();

    // 1: instruction fetch stall for 3 cycles, then the response arrives
    imem_read_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t1_stall", 32'(stall_v_o), 32'h3f);
      check("t1_flush", 32'(flush_v_o), 32'h0);
      tick();
    end
    imem_resp_v_i = 1'b1;
    #1;
    check("t1_resp_stall", 32'(stall_v_o), 32'h0);
    check("t1_no_timeout", 32'(timeout_v_o), 32'h0);
    tick(); idle();

    // 2: flush masks cover every younger stage
    br_v_i = 6'b001000; #1;
    check("t2_br3", 32'(flush_v_o), 32'h07);
    check("t2_br3_stall", 32'(stall_v_o), 32'h0);
    tick();
    br_v_i = 6'b100000; #1;
    check("t2_br5", 32'(flush_v_o), 32'h1f);
    tick();
    br_v_i = 6'b000001; #1;
    check("t2_br0_ignored", 32'(flush_v_o), 32'h0);
    tick();
    br_v_i = 6'b000000; #1;
    check("t2_none", 32'(flush_v_o), 32'h0);
    tick();

    // 3: a redirect during a dmem stall is deferred to the first free cycle
    dmem_read_v_i = 1'b1; #1;
    check("t3_stall", 32'(stall_v_o), 32'h3f);
    tick();
    br_v_i = 6'b000100; #1;
    check("t3_flush_held", 32'(flush_v_o), 32'h0);
    tick();
    br_v_i = '0; #1;
    check("t3_flush_held2", 32'(flush_v_o), 32'h0);
    tick();
    dmem_resp_v_i = 1'b1; #1;
    check("t3_flush_issue", 32'(flush_v_o), 32'h03);
    check("t3_free_stall", 32'(stall_v_o), 32'h0);
    tick(); idle(); #1;
    check("t3_flush_after", 32'(flush_v_o), 32'h0);
    tick();

    // 4: load-use on x5, including flush dominance and the extra stall cycle
    ld_issue_v_i = 1'b1; ld_issue_rd_i = 5'd5; #1;
    check("t4_issue_cycle", 32'(stall_v_o), 32'h0);
    tick();
    ld_issue_v_i = 1'b0; rs1_v_i = 1'b1; rs1_i = 5'd5; #1;
    check("t4_lu_stall", 32'(stall_v_o), 32'h07);
    check("t4_lu_bubble", 32'(bubble_v_o), 32'h1);
    tick(); #1;
    check("t4_lu_stall2", 32'(stall_v_o), 32'h07);
    tick();
    br_v_i = 6'b001000; #1;
    check("t4_flush_dom_flush", 32'(flush_v_o), 32'h07);
    check("t4_flush_dom_stall", 32'(stall_v_o), 32'h00);
    check("t4_flush_dom_bubble", 32'(bubble_v_o), 32'h0);
    tick();
    br_v_i = '0; ld_done_v_i = 1'b1; ld_done_rd_i = 5'd5; #1;
    check("t4_done_cycle_stall", 32'(stall_v_o), 32'h07);
    check("t4_done_cycle_bubble", 32'(bubble_v_o), 32'h1);
    tick();
    ld_done_v_i = 1'b0; #1;
    check("t4_released_stall", 32'(stall_v_o), 32'h0);
    check("t4_released_bubble", 32'(bubble_v_o), 32'h0);
    tick(); idle();
    ld_issue_v_i = 1'b1; ld_issue_rd_i = 5'd0;
    tick();
    ld_issue_v_i = 1'b0; rs1_v_i = 1'b1; rs1_i = 5'd0; #1;
    check("t4_x0_stall", 32'(stall_v_o), 32'h0);
    check("t4_x0_bubble", 32'(bubble_v_o), 32'h0);
    tick(); idle();
    // The same rd is issued and completed in one cycle, so the entry stays set.
    ld_issue_v_i = 1'b1; ld_issue_rd_i = 5'd7;
    ld_done_v_i  = 1'b1; ld_done_rd_i  = 5'd7;
    tick();
    ld_issue_v_i = 1'b0; ld_done_v_i = 1'b0;
    rs2_v_i = 1'b1; rs2_i = 5'd7; #1;
    check("t4_setwins_stall", 32'(stall_v_o), 32'h07);
    tick();
    imem_read_v_i = 1'b1; #1;
    check("t4_memlu_stall", 32'(stall_v_o), 32'h3f);
    check("t4_memlu_bubble", 32'(bubble_v_o), 32'h0);
    tick();
    imem_read_v_i = 1'b0; ld_done_v_i = 1'b1; ld_done_rd_i = 5'd7;
    tick(); idle(); rs2_v_i = 1'b1; rs2_i = 5'd7; #1;
    check("t4_x7_cleared", 32'(stall_v_o), 32'h0);
    tick(); idle();

    // 5: watchdog with MEM_TIMEOUT=4
    dmem_read_v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_timeout_low", 32'(timeout_v_o), 32'h0);
      tick();
    end
    #1;
    check("t5_timeout_set", 32'(timeout_v_o), 32'h1);
    dmem_resp_v_i = 1'b1;
    tick(); #1;
    check("t5_timeout_sticky", 32'(timeout_v_o), 32'h1);
    idle(); clr_timeout_i = 1'b1;
    tick(); #1;
    check("t5_timeout_clr", 32'(timeout_v_o), 32'h0);
    // The clear is held throughout; the set in the 4th stall cycle still wins.
    dmem_read_v_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("t5_set_beats_clr", 32'(timeout_v_o), 32'h1);
    idle();
    tick();

    // 6: reset asserted mid load-use stall with a pending flush
    ld_issue_v_i = 1'b1; ld_issue_rd_i = 5'd9;
    tick();
    ld_issue_v_i = 1'b0; rs1_v_i = 1'b1; rs1_i = 5'd9;
    dmem_read_v_i = 1'b1; br_v_i = 6'b010000; #1;
    check("t6_pre_stall", 32'(stall_v_o), 32'h3f);
    check("t6_pre_flush", 32'(flush_v_o), 32'h0);
    tick();
    br_v_i = '0;
    reset_n_i = 1'b0; #1;
    check("t6_rst_stall",   32'(stall_v_o),   32'h0);
    check("t6_rst_flush",   32'(flush_v_o),   32'h0);
    check("t6_rst_bubble",  32'(bubble_v_o),  32'h0);
    check("t6_rst_timeout", 32'(timeout_v_o), 32'h0);
    tick();
    reset_n_i = 1'b1; dmem_read_v_i = 1'b0; #1;
    check("t6_post_stall",  32'(stall_v_o),  32'h0);
    check("t6_post_flush",  32'(flush_v_o),  32'h0);
    check("t6_post_bubble", 32'(bubble_v_o), 32'h0);
    tick(); idle();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
